// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Combinational definitions only; no latency.
// No flow control; consumed by module_seg_scan and module_bcd7seg.
package seg_scan_pkg;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   typedef logic [3:0] digit_t;

   // Segment bus is {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [3:0] AN_OFF   = 4'hF;

endpackage

// File: rtl/module_seg_scan_bcd7seg.sv
// BCD digit to active-low {g..a} segment pattern; values above 9 render a dash.
// Purely combinational, zero latency.
// No flow control.
module module_bcd7seg
   import seg_scan_pkg::*;
(
   input  digit_t     i_dig,
   output logic [6:0] o_seg
);

   // Segment lookup, anything outside 0..9 falls through to the dash.
   always_comb begin
      o_seg = SEG_DASH;
      case (i_dig)
         4'd0:    o_seg = 7'b1000000;
         4'd1:    o_seg = 7'b1111001;
         4'd2:    o_seg = 7'b0100100;
         4'd3:    o_seg = 7'b0110000;
         4'd4:    o_seg = 7'b0011001;
         4'd5:    o_seg = 7'b0010010;
         4'd6:    o_seg = 7'b0000010;
         4'd7:    o_seg = 7'b1111000;
         4'd8:    o_seg = 7'b0000000;
         4'd9:    o_seg = 7'b0010000;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/module_seg_scan.sv
// Time-multiplexed 4-digit 7-segment scanner with frame-aligned digit update.
// All outputs registered, one clk after the state/index decision; no comb input-to-output path.
// No backpressure: loads always land in shadow, applied at the next frame boundary.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits 3..1.
module module_seg_scan
   import seg_scan_pkg::*;
#(
   parameter int SCAN_DIV     = 27000,
   parameter int BLANK_CYCLES = 27
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_i,
   input  logic       load_i,
   input  logic [3:0] unidades_input,
   input  logic [3:0] decenas_input,
   input  logic [3:0] centenas_input,
   input  logic [3:0] milesimas_input,
   output logic [6:0] seg_o,
   output logic [3:0] an_o,
   output logic [1:0] digit_idx_o,
   output logic       frame_o
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [1:0]      r_idx;
   logic [1:0]      w_idx_nxt;
   digit_t [3:0]    r_shadow;
   digit_t [3:0]    r_active;
   digit_t [3:0]    w_din;
   logic            r_pending;
   logic            r_restart;
   logic            w_boundary;
   logic [6:0]      r_seg;
   logic [6:0]      w_seg_nxt;
   logic [6:0]      w_dec;
   logic [3:0]      r_an;
   logic [3:0]      w_an_nxt;
   logic            r_frame;
   logic [3:0]      w_sup;

   assign w_din = {milesimas_input, centenas_input, decenas_input, unidades_input};

   // A SHOW slot never starts on an edge that changes active, so decoding
   // the current digit of the current active set is always the right glyph.
   module_bcd7seg u_dec (
      .i_dig (r_active[r_idx]),
      .o_seg (w_dec)
   );

   // Leading-zero suppression mask: bit p set when digit p and all above are zero.
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      w_sup    = '0;
      w_sup[3] = (r_active[3] == 4'd0);
      w_sup[2] = w_sup[3] && (r_active[2] == 4'd0);
      w_sup[1] = w_sup[2] && (r_active[1] == 4'd0);
      w_sup[0] = 1'b0;
   end
`else
   always_comb begin
      w_sup = '0;
   end
`endif

   // Next state, slot counter, digit index and frame-boundary detection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_boundary  = 1'b0;
      if (!enable_i) begin
         w_state_nxt = S_BLANK;
         w_idx_nxt   = 2'd0;
         w_cnt_nxt   = '0;
      end else if (r_restart) begin
         // Re-enable counts as a fresh frame start on digit 0.
         w_state_nxt = S_BLANK;
         w_idx_nxt   = 2'd0;
         w_cnt_nxt   = '0;
         w_boundary  = 1'b1;
      end else begin
         case (r_state)
            S_BLANK: begin
               if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
                  w_state_nxt = S_SHOW;
                  w_cnt_nxt   = '0;
               end
            end
            S_SHOW: begin
               if (r_cnt == CW'(SCAN_DIV - 1)) begin
                  w_state_nxt = S_BLANK;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = r_idx + 2'd1;
                  w_boundary  = (r_idx == 2'd3);
               end
            end
            default: begin
               w_state_nxt = S_BLANK;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Pin values for the coming cycle; dark unless entering/staying in a lit SHOW slot.
   always_comb begin
      w_seg_nxt = SEG_OFF;
      w_an_nxt  = AN_OFF;
      if (w_state_nxt == S_SHOW && !w_sup[r_idx]) begin
         w_seg_nxt = w_dec;
         w_an_nxt  = ~(4'b0001 << r_idx);
      end
   end

   // Scan FSM state, counter, index and registered pin drivers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_BLANK;
         r_cnt     <= '0;
         r_idx     <= 2'd0;
         r_restart <= 1'b0;
         r_seg     <= SEG_OFF;
         r_an      <= AN_OFF;
         r_frame   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_idx     <= w_idx_nxt;
         r_restart <= !enable_i;
         r_seg     <= w_seg_nxt;
         r_an      <= w_an_nxt;
         r_frame   <= w_boundary;
      end
   end

   // Shadow/active digit registers; a load on the boundary edge bypasses shadow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (load_i) begin
            r_shadow <= w_din;
         end
         if (w_boundary) begin
            r_pending <= 1'b0;
            if (load_i) begin
               r_active <= w_din;
            end else if (r_pending) begin
               r_active <= r_shadow;
            end
         end else if (load_i) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign seg_o       = r_seg;
   assign an_o        = r_an;
   assign digit_idx_o = r_idx;
   assign frame_o     = r_frame;

endmodule

// File: tb/tb_module_seg_scan.sv
// Randomized scoreboard bench for module_seg_scan using a frame-position reference model.
// Expected pins are pushed per clock after each edge; a negedge monitor pops and compares.
// Honors LEADING_ZERO_BLANK_EN in the model when the macro is defined.
module tb_module_seg_scan;

   localparam int SD   = 4;
   localparam int BC   = 1;
   localparam int SLOT = SD + BC;
   localparam int FR   = 4 * SLOT;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       load_i;
   logic [3:0] unidades_input;
   logic [3:0] decenas_input;
   logic [3:0] centenas_input;
   logic [3:0] milesimas_input;
   logic [6:0] seg_o;
   logic [3:0] an_o;
   logic [1:0] digit_idx_o;
   logic       frame_o;

   module_seg_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable_i        (enable_i),
      .load_i          (load_i),
      .unidades_input  (unidades_input),
      .decenas_input   (decenas_input),
      .centenas_input  (centenas_input),
      .milesimas_input (milesimas_input),
      .seg_o           (seg_o),
      .an_o            (an_o),
      .digit_idx_o     (digit_idx_o),
      .frame_o         (frame_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [13:0] q[$];

   // Reference model: position inside the 20-cycle frame timeline.
   int          ph;
   bit          dark;
   logic [15:0] m_act;
   logic [15:0] m_sh;
   bit          m_pend;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic bit suppressed(input int d, input logic [15:0] a);
`ifdef LEADING_ZERO_BLANK_EN
      if (d == 0) return 1'b0;
      for (int p = d; p < 4; p++)
         if (a[4*p +: 4] != 4'd0) return 1'b0;
      return 1'b1;
`else
      return (d < 0) || (a === 16'hxxxx);
`endif
   endfunction

   task automatic model_reset();
      ph = 0; dark = 0; m_act = '0; m_sh = '0; m_pend = 0;
      q.delete();
   endtask

   // One clock: let the DUT take the edge, advance the model, queue expected pins.
   task automatic tick();
      bit          bnd;
      logic [15:0] din;
      logic [6:0]  e_seg;
      logic [3:0]  e_an;
      int          d;
      @(posedge clk);
      din = {milesimas_input, centenas_input, decenas_input, unidades_input};
      bnd = 0;
      if (!enable_i) dark = 1;
      else if (dark) begin dark = 0; ph = 0; bnd = 1; end
      else begin ph = (ph + 1) % FR; bnd = (ph == 0); end
      if (bnd && load_i) begin m_act = din; m_pend = 0; end
      else if (bnd && m_pend) begin m_act = m_sh; m_pend = 0; end
      if (load_i) begin m_sh = din; if (!bnd) m_pend = 1; end
      e_seg = 7'h7F; e_an = 4'hF; d = 0;
      if (enable_i) begin
         d = ph / SLOT;
         if ((ph % SLOT) >= BC && !suppressed(d, m_act)) begin
            e_seg = dec(m_act[4*d +: 4]);
            e_an  = 4'hF & ~(4'b0001 << d);
         end
      end
      #1 q.push_back({e_seg, e_an, 2'(d), bnd});
   endtask

   task automatic do_load(input logic [3:0] m, input logic [3:0] c,
                          input logic [3:0] dd, input logic [3:0] u);
      milesimas_input = m; centenas_input = c; decenas_input = dd; unidades_input = u;
      load_i = 1'b1;
      tick();
      load_i = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: compare every presented output cycle against the scoreboard.
   initial begin
      logic [13:0] e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("pins{seg,an,idx,frame}", {seg_o, an_o, digit_idx_o, frame_o}, e);
         end
      end
   end

   initial begin
      rst = 1'b0; enable_i = 1'b1; load_i = 1'b0;
      unidades_input = '0; decenas_input = '0; centenas_input = '0; milesimas_input = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      check("reset_seg", seg_o, 7'h7F);
      check("reset_an", an_o, 4'hF);
      check("reset_idx", digit_idx_o, 2'd0);
      check("reset_frame", frame_o, 1'b0);
      rst = 1'b1;

      // Idle scanning of zeros.
      run(45);
      // 7609, then a mid-frame overwrite with 3193.
      do_load(4'd7, 4'd6, 4'd0, 4'd9);
      run(30);
      for (int i = 0; i < FR && ph != 10; i++) tick();
      do_load(4'd3, 4'd1, 4'd9, 4'd3);
      run(30);
      // Load landing exactly on the frame boundary edge, including a dash digit.
      for (int i = 0; i < FR && ph != FR - 1; i++) tick();
      do_load(4'd2, 4'd0, 4'hA, 4'd5);
      run(25);
      // Leading zeros: 0094 and 0000.
      do_load(4'd0, 4'd0, 4'd9, 4'd4);
      run(45);
      do_load(4'd0, 4'd0, 4'd0, 4'd0);
      run(45);
      // Dark for 7 cycles, with a load captured while dark.
      enable_i = 1'b0;
      run(3);
      do_load(4'd1, 4'd2, 4'd3, 4'd4);
      run(3);
      enable_i = 1'b1;
      run(25);

      // Asynchronous reset in the middle of a SHOW slot.
      for (int i = 0; i < FR && !((ph % SLOT) >= BC && ph / SLOT == 1); i++) tick();
      do_load(4'd8, 4'd8, 4'd8, 4'd8);
      #2 rst = 1'b0;
      #1;
      check("async_rst_an", an_o, 4'hF);
      check("async_rst_seg", seg_o, 7'h7F);
      check("async_rst_frame", frame_o, 1'b0);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      run(25);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (enable_i) begin
            if ($urandom_range(0, 99) < 2) enable_i = 1'b0;
         end else if ($urandom_range(0, 99) < 20) enable_i = 1'b1;
         milesimas_input = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         centenas_input  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         decenas_input   = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         unidades_input  = 4'($urandom_range(0, 15));
         load_i = ($urandom_range(0, 7) == 0);
         tick();
      end
      load_i = 1'b0;
      @(negedge clk);
      #1;
      check("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
